lc3b_ctrl_pipe: RTL and testbench
=================================

Name: lc3b_ctrl_pipe

Overview:
- Parametrised control-word pipeline for the LC-3b core. Sits after the per-opcode control generator.
- Carries each decoded control word, with valid, dest and load tags, through NUM_STAGES pipeline registers (default ID/EX, EX/MEM, MEM/WB).
- Owns stall, bubble and flush sequencing: data-memory freeze, load-use interlock, taken-branch squash. Drives the ID-slot accept handshake.

Parameters:
CTRL_W, 32, width of packed control word
NUM_STAGES, 3, number of control registers after ID (legal: 2..8)
DEST_W, 3, register index width
FLUSH_STAGE, 1, stage index whose instruction resolves taken branches (legal: 0..NUM_STAGES-2)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
id_valid  in  1  ID slot holds a real instruction
id_ctrl  in  CTRL_W  decoded control word
id_dest  in  DEST_W  destination register
id_wr  in  1  instruction writes regfile
id_is_load  in  1  instruction reads data memory into regfile
id_src1, id_src2  in  DEST_W  source registers
id_src1_used, id_src2_used  in  1  source actually read
dmem_stall  in  1  data memory not ready this cycle
flush  in  1  instruction in stage FLUSH_STAGE is a taken branch; held by requester until taken
id_accept  out  1  ID slot consumed this cycle; upstream loads IF/ID when id_accept or !id_valid
ifid_flush  out  1  upstream must invalidate IF/ID on this edge
hazard  out  1  load-use interlock active
stage_valid  out  NUM_STAGES  bit k = stage k valid
stage_ctrl  out  NUM_STAGES*CTRL_W  stage k at bits [k*CTRL_W +: CTRL_W]
stage_dest  out  NUM_STAGES*DEST_W  packed likewise
stage_wr  out  NUM_STAGES  regfile write tag, forced 0 when invalid
stall_cnt, bubble_cnt, flush_cnt  out  32 each  performance counters

Behaviour:
- Reset (async assert, sync-safe deassert): all stage_valid, stage_ctrl, stage_dest, stage_wr and is_load tags = 0; counters = 0.
- hazard (combinational) = !dmem_stall && !flush && id_valid && stage_valid[0] && stage0.is_load && stage0.wr && ((id_src1_used && id_src1==stage0.dest) || (id_src2_used && id_src2==stage0.dest)).
- Bubble definition: valid=0, ctrl=0, dest=0, wr=0, is_load=0.
- Each cycle exactly one rule applies, in priority order:
  1. dmem_stall=1: every stage holds. id_accept=0, ifid_flush=0. flush is not taken.
  2. flush=1: stages k>FLUSH_STAGE+1 load from k-1. Stage FLUSH_STAGE+1 loads the branch. Stages 0..FLUSH_STAGE become bubbles. id_accept=1 (ID slot discarded). ifid_flush=1.
  3. hazard=1: stages k>=1 load from k-1; stage 0 becomes a bubble. id_accept=0.
  4. Otherwise: all advance. Stage 0 loads the ID fields, or a bubble if !id_valid. id_accept=id_valid.
- Latency: an accepted instruction reaches stage k after k+1 non-frozen edges.
- Last stage drops its entry each advancing edge; there is no output backpressure other than dmem_stall.
- id_accept, ifid_flush and hazard are combinational from current state and inputs; no combinational path from flush to hazard.
- Reset asserted mid-stall or mid-flush clears everything immediately; the first cycle after release is rule 4 with empty stages.

Optional Feature:
LC3B_CTRL_PIPE_PERF_EN
- Defined: 32-bit saturating counters.
  - stall_cnt +1 per rule-1 cycle.
  - bubble_cnt +1 per rule-3 cycle.
  - flush_cnt +1 per rule-2 cycle.
  - Each saturates at 0xFFFFFFFF and is cleared by reset.
- Undefined: the three ports are tied to 0 and no counter flops are built.

Test Plan:
- Reset: hold reset_n=0 with id_valid=1. Required: stage_valid=000, id_accept=0 after release until the first edge, counters 0.
- Straight-line flow: ADD to R1, then AND, then NOT, back to back. Required: ADD's ctrl appears at stage 0/1/2 on edges 1/2/3; stage_valid ramps 001, 011, 111.
- Load-use: LDR R2 then ADD R3,R2,R4. Required: one cycle with hazard=1 and id_accept=0; stage 0 bubble; ADD enters stage 0 one edge later. With PERF_EN, bubble_cnt=1. The same pair with ADD using only R4 gives no hazard.
- dmem_stall=1 for 3 cycles with 3 valid stages. Required: stage contents unchanged for 3 edges, id_accept=0, stall_cnt=3. A flush raised during the stall takes effect on the first unstalled edge.
- Flush with FLUSH_STAGE=1: BR in stage 1, younger valid instructions in stage 0 and the ID slot. Required: after the edge, stage 2 holds BR, stages 0-1 are bubbles, ifid_flush=1, flush_cnt=1.
- Simultaneous flush and hazard. Required: flush wins, hazard=0, no bubble counted. Re-run with NUM_STAGES=5 and FLUSH_STAGE=3 and check the same squash pattern on stages 0-3.

Source files
------------

// File: rtl/lc3b_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// lc3b_ctrl_pipe
//
// Control-word pipeline for the LC-3b core. It takes each decoded control
// word from the ID slot and carries it, with its valid, destination,
// regfile-write and load tags, through NUM_STAGES registers (by default
// ID/EX, EX/MEM, MEM/WB). It also decides every cycle whether to stall,
// insert a bubble or squash:
//   - data-memory freeze (dmem_stall): the whole pipe holds
//   - taken-branch squash (flush): stages 0..FLUSH_STAGE are killed, the
//     branch moves on, and the IF/ID slot is invalidated upstream
//   - load-use interlock (hazard): the ID slot waits one cycle and a
//     bubble enters stage 0
//
// Optional feature macro: LC3B_CTRL_PIPE_PERF_EN
//   defined   -> 32-bit saturating stall/bubble/flush event counters
//   undefined -> counter ports tied to zero, no counter flops
//
// Ports:
//   clk, reset_n                     clock (rising edge), async active-low reset
//   id_valid, id_ctrl, id_dest,
//   id_wr, id_is_load                ID-slot instruction and its tags
//   id_src1/2, id_src1/2_used        ID-slot source registers
//   dmem_stall                       data memory not ready this cycle
//   flush                            stage FLUSH_STAGE holds a taken branch
//   id_accept                        ID slot consumed this cycle
//   ifid_flush                       upstream must invalidate IF/ID
//   hazard                           load-use interlock active
//   stage_valid/ctrl/dest/wr         per-stage state, stage k at slice k
//   stall_cnt, bubble_cnt, flush_cnt performance counters
// ---------------------------------------------------------------------------
module lc3b_ctrl_pipe #(
    parameter int CTRL_W      = 32,
    parameter int NUM_STAGES  = 3,
    parameter int DEST_W      = 3,
    parameter int FLUSH_STAGE = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         id_valid,
    input  logic [CTRL_W-1:0]            id_ctrl,
    input  logic [DEST_W-1:0]            id_dest,
    input  logic                         id_wr,
    input  logic                         id_is_load,
    input  logic [DEST_W-1:0]            id_src1,
    input  logic [DEST_W-1:0]            id_src2,
    input  logic                         id_src1_used,
    input  logic                         id_src2_used,
    input  logic                         dmem_stall,
    input  logic                         flush,
    output logic                         id_accept,
    output logic                         ifid_flush,
    output logic                         hazard,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl,
    output logic [NUM_STAGES*DEST_W-1:0] stage_dest,
    output logic [NUM_STAGES-1:0]        stage_wr,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  bubble_cnt,
    output logic [31:0]                  flush_cnt
);

    // Which sequencing rule governs the current cycle.
    typedef enum logic [1:0] {
        RULE_ADV   = 2'd0,
        RULE_HAZ   = 2'd1,
        RULE_FLUSH = 2'd2,
        RULE_STALL = 2'd3
    } rule_e;

    // Stage state; index k of each packed array is pipeline stage k.
    logic [NUM_STAGES-1:0]             r_valid;
    logic [NUM_STAGES-1:0][CTRL_W-1:0] r_ctrl;
    logic [NUM_STAGES-1:0][DEST_W-1:0] r_dest;
    logic [NUM_STAGES-1:0]             r_wr;
    logic [NUM_STAGES-1:0]             r_load;

    logic [NUM_STAGES-1:0]             w_valid_nxt;
    logic [NUM_STAGES-1:0][CTRL_W-1:0] w_ctrl_nxt;
    logic [NUM_STAGES-1:0][DEST_W-1:0] w_dest_nxt;
    logic [NUM_STAGES-1:0]             w_wr_nxt;
    logic [NUM_STAGES-1:0]             w_load_nxt;

    logic  w_load_use;
    rule_e w_rule;

    // Load-use detect: the ID instruction reads the register that a load
    // sitting in stage 0 has not yet produced.
    always_comb begin
        w_load_use = 1'b0;
        if (id_valid && r_valid[0] && r_load[0] && r_wr[0]) begin
            w_load_use = (id_src1_used && (id_src1 == r_dest[0])) ||
                         (id_src2_used && (id_src2 == r_dest[0]));
        end else begin
            w_load_use = 1'b0;
        end
    end

    // Priority select of the cycle rule: freeze, squash, interlock, advance.
    always_comb begin
        w_rule = RULE_ADV;
        if (dmem_stall) begin
            w_rule = RULE_STALL;
        end else if (flush) begin
            w_rule = RULE_FLUSH;
        end else if (w_load_use) begin
            w_rule = RULE_HAZ;
        end else begin
            w_rule = RULE_ADV;
        end
    end

    // Handshake outputs; held low while reset is asserted so upstream never
    // sees the ID slot consumed during reset.
    always_comb begin
        hazard     = 1'b0;
        id_accept  = 1'b0;
        ifid_flush = 1'b0;
        if (reset_n) begin
            hazard     = (w_rule == RULE_HAZ);
            ifid_flush = (w_rule == RULE_FLUSH);
            // A squashed ID slot counts as consumed: it is discarded.
            id_accept  = (w_rule == RULE_FLUSH) ||
                         ((w_rule == RULE_ADV) && id_valid);
        end else begin
            hazard     = 1'b0;
            ifid_flush = 1'b0;
            id_accept  = 1'b0;
        end
    end

    // Next-state for every stage according to the selected rule.
    always_comb begin
        w_valid_nxt = r_valid;
        w_ctrl_nxt  = r_ctrl;
        w_dest_nxt  = r_dest;
        w_wr_nxt    = r_wr;
        w_load_nxt  = r_load;
        case (w_rule)
            RULE_STALL: begin
                w_valid_nxt = r_valid;
                w_ctrl_nxt  = r_ctrl;
                w_dest_nxt  = r_dest;
                w_wr_nxt    = r_wr;
                w_load_nxt  = r_load;
            end
            RULE_FLUSH: begin
                // Older than the branch (and the branch itself) move on;
                // everything younger than the branch is killed.
                for (int k = 1; k < NUM_STAGES; k++) begin
                    if (k > FLUSH_STAGE) begin
                        w_valid_nxt[k] = r_valid[k-1];
                        w_ctrl_nxt[k]  = r_ctrl[k-1];
                        w_dest_nxt[k]  = r_dest[k-1];
                        w_wr_nxt[k]    = r_wr[k-1];
                        w_load_nxt[k]  = r_load[k-1];
                    end else begin
                        w_valid_nxt[k] = 1'b0;
                        w_ctrl_nxt[k]  = {CTRL_W{1'b0}};
                        w_dest_nxt[k]  = {DEST_W{1'b0}};
                        w_wr_nxt[k]    = 1'b0;
                        w_load_nxt[k]  = 1'b0;
                    end
                end
                w_valid_nxt[0] = 1'b0;
                w_ctrl_nxt[0]  = {CTRL_W{1'b0}};
                w_dest_nxt[0]  = {DEST_W{1'b0}};
                w_wr_nxt[0]    = 1'b0;
                w_load_nxt[0]  = 1'b0;
            end
            RULE_HAZ, RULE_ADV: begin
                for (int k = 1; k < NUM_STAGES; k++) begin
                    w_valid_nxt[k] = r_valid[k-1];
                    w_ctrl_nxt[k]  = r_ctrl[k-1];
                    w_dest_nxt[k]  = r_dest[k-1];
                    w_wr_nxt[k]    = r_wr[k-1];
                    w_load_nxt[k]  = r_load[k-1];
                end
                if ((w_rule == RULE_ADV) && id_valid) begin
                    w_valid_nxt[0] = 1'b1;
                    w_ctrl_nxt[0]  = id_ctrl;
                    w_dest_nxt[0]  = id_dest;
                    w_wr_nxt[0]    = id_wr;
                    w_load_nxt[0]  = id_is_load;
                end else begin
                    w_valid_nxt[0] = 1'b0;
                    w_ctrl_nxt[0]  = {CTRL_W{1'b0}};
                    w_dest_nxt[0]  = {DEST_W{1'b0}};
                    w_wr_nxt[0]    = 1'b0;
                    w_load_nxt[0]  = 1'b0;
                end
            end
            default: begin
                w_valid_nxt = r_valid;
                w_ctrl_nxt  = r_ctrl;
                w_dest_nxt  = r_dest;
                w_wr_nxt    = r_wr;
                w_load_nxt  = r_load;
            end
        endcase
    end

    // Stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= {NUM_STAGES{1'b0}};
            r_ctrl  <= '0;
            r_dest  <= '0;
            r_wr    <= {NUM_STAGES{1'b0}};
            r_load  <= {NUM_STAGES{1'b0}};
        end else begin
            r_valid <= w_valid_nxt;
            r_ctrl  <= w_ctrl_nxt;
            r_dest  <= w_dest_nxt;
            r_wr    <= w_wr_nxt;
            r_load  <= w_load_nxt;
        end
    end

    assign stage_valid = r_valid;
    assign stage_ctrl  = r_ctrl;
    assign stage_dest  = r_dest;
    // Write tag is qualified by valid so a stale tag can never reach the regfile.
    assign stage_wr    = r_wr & r_valid;

`ifdef LC3B_CTRL_PIPE_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 32'd1;
        end
    endfunction

    // Event counters, one increment per cycle of the matching rule.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
            r_flush_cnt  <= 32'd0;
        end else begin
            case (w_rule)
                RULE_STALL: r_stall_cnt  <= sat_inc(r_stall_cnt);
                RULE_HAZ:   r_bubble_cnt <= sat_inc(r_bubble_cnt);
                RULE_FLUSH: r_flush_cnt  <= sat_inc(r_flush_cnt);
                default: begin
                    r_stall_cnt  <= r_stall_cnt;
                    r_bubble_cnt <= r_bubble_cnt;
                    r_flush_cnt  <= r_flush_cnt;
                end
            endcase
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`else
    assign stall_cnt  = 32'd0;
    assign bubble_cnt = 32'd0;
    assign flush_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_lc3b_ctrl_pipe.sv
module tb_lc3b_ctrl_pipe;

`ifdef LC3B_CTRL_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, id_valid, id_wr, id_is_load, src1_used, src2_used;
    logic        dmem_stall, flush;
    logic [31:0] id_ctrl;
    logic [2:0]  id_dest, id_src1, id_src2;

    // Default instance: 3 stages, branch resolved in stage 1
    logic        a_acc, a_ifid, a_haz;
    logic [2:0]  a_valid, a_wr;
    logic [95:0] a_ctrl;
    logic [8:0]  a_dest;
    logic [31:0] a_scnt, a_bcnt, a_fcnt;
    // Deep instance: 5 stages, branch resolved in stage 3
    logic         b_acc, b_ifid, b_haz;
    logic [4:0]   b_valid, b_wr;
    logic [159:0] b_ctrl;
    logic [14:0]  b_dest;
    logic [31:0]  b_scnt, b_bcnt, b_fcnt;

    lc3b_ctrl_pipe dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_dest(id_dest), .id_wr(id_wr), .id_is_load(id_is_load),
        .id_src1(id_src1), .id_src2(id_src2), .id_src1_used(src1_used),
        .id_src2_used(src2_used), .dmem_stall(dmem_stall), .flush(flush),
        .id_accept(a_acc), .ifid_flush(a_ifid), .hazard(a_haz),
        .stage_valid(a_valid), .stage_ctrl(a_ctrl), .stage_dest(a_dest),
        .stage_wr(a_wr), .stall_cnt(a_scnt), .bubble_cnt(a_bcnt), .flush_cnt(a_fcnt));

    lc3b_ctrl_pipe #(.NUM_STAGES(5), .FLUSH_STAGE(3)) dut5 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_dest(id_dest), .id_wr(id_wr), .id_is_load(id_is_load),
        .id_src1(id_src1), .id_src2(id_src2), .id_src1_used(src1_used),
        .id_src2_used(src2_used), .dmem_stall(dmem_stall), .flush(flush),
        .id_accept(b_acc), .ifid_flush(b_ifid), .hazard(b_haz),
        .stage_valid(b_valid), .stage_ctrl(b_ctrl), .stage_dest(b_dest),
        .stage_wr(b_wr), .stall_cnt(b_scnt), .bubble_cnt(b_bcnt), .flush_cnt(b_fcnt));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each model pipe is a list of entries, position 0 = youngest.
    typedef struct packed {
        logic        v;
        logic [31:0] c;
        logic [2:0]  d;
        logic        wr;
        logic        ld;
    } ent_t;

    ent_t        st [2][8];
    int          ns [2];
    int          fs [2];
    int unsigned cs [2];
    int unsigned cb [2];
    int unsigned cf [2];

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 8; k++) st[m][k] = '0;
            cs[m] = 0; cb[m] = 0; cf[m] = 0;
        end
    endtask

    function automatic logic m_haz(input int m);
        ent_t y;
        y = st[m][0];
        if (!reset_n || dmem_stall || flush || !id_valid) return 1'b0;
        if (!(y.v && y.ld && y.wr)) return 1'b0;
        return (src1_used && id_src1 == y.d) || (src2_used && id_src2 == y.d);
    endfunction

    function automatic logic m_acc(input int m);
        if (!reset_n || dmem_stall) return 1'b0;
        if (flush) return 1'b1;
        if (m_haz(m)) return 1'b0;
        return id_valid;
    endfunction

    task automatic m_step();
        for (int m = 0; m < 2; m++) begin
            ent_t ins;
            logic h;
            h = m_haz(m);
            if (dmem_stall) begin
                cs[m] = (cs[m] == 32'hFFFF_FFFF) ? cs[m] : cs[m] + 1;
            end else begin
                // Everything drifts one place deeper, the oldest falls off,
                // the ID entry (or a bubble) lands at the front.
                ins = '0;
                if (!flush && !h && id_valid)
                    ins = '{v: 1'b1, c: id_ctrl, d: id_dest, wr: id_wr, ld: id_is_load};
                for (int k = ns[m] - 1; k >= 1; k--) st[m][k] = st[m][k-1];
                st[m][0] = ins;
                if (flush) begin
                    for (int k = 0; k <= fs[m]; k++) st[m][k] = '0;
                    cf[m] = (cf[m] == 32'hFFFF_FFFF) ? cf[m] : cf[m] + 1;
                end else if (h) begin
                    cb[m] = (cb[m] == 32'hFFFF_FFFF) ? cb[m] : cb[m] + 1;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            logic [255:0] ev, ec, ed, ew;
            string p;
            p = (m == 0) ? "s3" : "s5";
            ev = '0; ec = '0; ed = '0; ew = '0;
            for (int k = 0; k < ns[m]; k++) begin
                ev[k]        = st[m][k].v;
                ec[k*32 +: 32] = st[m][k].c;
                ed[k*3 +: 3]   = st[m][k].d;
                ew[k]        = st[m][k].v & st[m][k].wr;
            end
            if (m == 0) begin
                chk({p, " valid"}, a_valid, ev);
                chk({p, " ctrl"}, a_ctrl, ec);
                chk({p, " dest"}, a_dest, ed);
                chk({p, " wr"}, a_wr, ew);
                chk({p, " hazard"}, a_haz, m_haz(m));
                chk({p, " accept"}, a_acc, m_acc(m));
                chk({p, " ifid_flush"}, a_ifid, reset_n && !dmem_stall && flush);
                chk({p, " stall_cnt"}, a_scnt, PERF ? cs[m] : 0);
                chk({p, " bubble_cnt"}, a_bcnt, PERF ? cb[m] : 0);
                chk({p, " flush_cnt"}, a_fcnt, PERF ? cf[m] : 0);
            end else begin
                chk({p, " valid"}, b_valid, ev);
                chk({p, " ctrl"}, b_ctrl, ec);
                chk({p, " dest"}, b_dest, ed);
                chk({p, " wr"}, b_wr, ew);
                chk({p, " hazard"}, b_haz, m_haz(m));
                chk({p, " accept"}, b_acc, m_acc(m));
                chk({p, " ifid_flush"}, b_ifid, reset_n && !dmem_stall && flush);
                chk({p, " stall_cnt"}, b_scnt, PERF ? cs[m] : 0);
                chk({p, " bubble_cnt"}, b_bcnt, PERF ? cb[m] : 0);
                chk({p, " flush_cnt"}, b_fcnt, PERF ? cf[m] : 0);
            end
        end
    endtask

    // Called just after a falling edge with inputs set; ends after the next falling edge.
    task automatic do_cycle();
        if (!reset_n) m_reset();
        #1;
        check_all();
        if (reset_n) m_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        id_valid = 1'b0; id_ctrl = 32'd0; id_dest = 3'd0; id_wr = 1'b0;
        id_is_load = 1'b0; id_src1 = 3'd0; id_src2 = 3'd0;
        src1_used = 1'b0; src2_used = 1'b0; dmem_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_ins(input logic [31:0] c, input logic [2:0] d, input logic wr,
                           input logic ld, input logic [2:0] s1, input logic u1,
                           input logic [2:0] s2, input logic u2);
        id_valid = 1'b1; id_ctrl = c; id_dest = d; id_wr = wr; id_is_load = ld;
        id_src1 = s1; src1_used = u1; id_src2 = s2; src2_used = u2;
    endtask

    localparam logic [31:0] ADD = 32'hA0D0_0001, ANDI = 32'hA0D0_0002, NOTI = 32'hA0D0_0003;
    localparam logic [31:0] LDR = 32'h6000_0002, ADD2 = 32'h1000_0003;
    localparam logic [31:0] BR = 32'hB000_0000, BR5 = 32'hB000_0005;

    initial begin
        logic [95:0] snap;
        logic [31:0] c0, b0, f0;
        ns[0] = 3; fs[0] = 1; ns[1] = 5; fs[1] = 3;
        set_idle();
        id_valid = 1'b1;
        reset_n = 1'b0;
        m_reset();
        @(negedge clk);

        // Reset held with a valid ID slot
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst valid", a_valid, 3'b000);
            chk("rst accept", a_acc, 1'b0);
            chk("rst stall_cnt", a_scnt, 32'd0);
            do_cycle();
        end
        reset_n = 1'b1;
        set_idle();
        chk("post-release valid", a_valid, 3'b000);

        // Straight-line ADD, AND, NOT
        set_ins(ADD, 3'd1, 1'b1, 1'b0, 3'd2, 1'b1, 3'd3, 1'b1);
        do_cycle();
        chk("sl e1 valid", a_valid, 3'b001);
        chk("sl e1 s0 ctrl", a_ctrl[31:0], ADD);
        set_ins(ANDI, 3'd2, 1'b1, 1'b0, 3'd1, 1'b1, 3'd0, 1'b0);
        do_cycle();
        chk("sl e2 valid", a_valid, 3'b011);
        chk("sl e2 s1 ctrl", a_ctrl[63:32], ADD);
        set_ins(NOTI, 3'd3, 1'b1, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0);
        do_cycle();
        chk("sl e3 valid", a_valid, 3'b111);
        chk("sl e3 s2 ctrl", a_ctrl[95:64], ADD);
        set_idle();
        repeat (5) do_cycle();

        // Load-use: LDR R2 then ADD R3,R2,R4
        set_ins(LDR, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0);
        do_cycle();
        set_ins(ADD2, 3'd3, 1'b1, 1'b0, 3'd2, 1'b1, 3'd4, 1'b1);
        b0 = a_bcnt;
        #1;
        chk("lu hazard", a_haz, 1'b1);
        chk("lu accept", a_acc, 1'b0);
        do_cycle();
        chk("lu bubble", a_valid, 3'b010);
        do_cycle();
        chk("lu add enters valid", a_valid, 3'b101);
        chk("lu add enters ctrl", a_ctrl[31:0], ADD2);
        chk("lu bubble_cnt", a_bcnt, PERF ? b0 + 32'd1 : 32'd0);
        set_idle();
        repeat (5) do_cycle();
        set_ins(LDR, 3'd2, 1'b1, 1'b1, 3'd5, 1'b1, 3'd0, 1'b0);
        do_cycle();
        set_ins(ADD2, 3'd3, 1'b1, 1'b0, 3'd4, 1'b1, 3'd2, 1'b0);
        #1;
        chk("no-lu hazard", a_haz, 1'b0);
        chk("no-lu accept", a_acc, 1'b1);
        do_cycle();
        set_idle();
        repeat (5) do_cycle();

        // dmem_stall for 3 cycles with 3 valid stages, flush raised in the last
        for (int i = 1; i <= 3; i++) begin
            set_ins(32'hC000_0000 + 32'(i), 3'(i), 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
            do_cycle();
        end
        set_ins(32'hC000_0004, 3'd4, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        dmem_stall = 1'b1;
        snap = a_ctrl;
        c0 = a_scnt;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) flush = 1'b1;
            #1;
            chk("stall accept", a_acc, 1'b0);
            chk("stall ifid_flush", a_ifid, 1'b0);
            do_cycle();
            chk("stall hold ctrl", a_ctrl, snap);
            chk("stall hold valid", a_valid, 3'b111);
        end
        chk("stall_cnt", a_scnt, PERF ? c0 + 32'd3 : 32'd0);
        dmem_stall = 1'b0;
        #1;
        chk("post-stall ifid_flush", a_ifid, 1'b1);
        do_cycle();
        chk("post-stall flush valid", a_valid, 3'b100);
        chk("post-stall flush s2", a_ctrl[95:64], snap[63:32]);
        set_idle();
        repeat (5) do_cycle();

        // Flush together with a load-use condition
        set_ins(BR, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        do_cycle();
        set_ins(32'h6000_0005, 3'd5, 1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0);
        do_cycle();
        set_ins(32'h1000_0007, 3'd6, 1'b1, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0);
        flush = 1'b1;
        f0 = a_fcnt;
        b0 = a_bcnt;
        #1;
        chk("fh hazard", a_haz, 1'b0);
        chk("fh accept", a_acc, 1'b1);
        chk("fh ifid_flush", a_ifid, 1'b1);
        do_cycle();
        chk("fh valid", a_valid, 3'b100);
        chk("fh s2 branch", a_ctrl[95:64], BR);
        chk("fh flush_cnt", a_fcnt, PERF ? f0 + 32'd1 : 32'd0);
        chk("fh bubble_cnt", a_bcnt, PERF ? b0 : 32'd0);
        set_idle();
        repeat (6) do_cycle();

        // Five-stage pipe, branch resolved in stage 3
        set_ins(BR5, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        do_cycle();
        for (int i = 1; i <= 3; i++) begin
            set_ins(32'hD000_0000 + 32'(i), 3'(i), 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
            do_cycle();
        end
        set_ins(32'hD000_0009, 3'd1, 1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
        flush = 1'b1;
        #1;
        chk("s5 ifid_flush", b_ifid, 1'b1);
        do_cycle();
        chk("s5 valid", b_valid, 5'b10000);
        chk("s5 s4 branch", b_ctrl[159:128], BR5);
        set_idle();
        repeat (6) do_cycle();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n    = ($urandom_range(0, 199) != 0);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_ctrl    = $urandom;
            id_dest    = 3'($urandom_range(0, 3));
            id_wr      = ($urandom_range(0, 3) != 0);
            id_is_load = ($urandom_range(0, 1) != 0);
            id_src1    = 3'($urandom_range(0, 3));
            id_src2    = 3'($urandom_range(0, 3));
            src1_used  = ($urandom_range(0, 1) != 0);
            src2_used  = ($urandom_range(0, 1) != 0);
            dmem_stall = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 6) == 0);
            do_cycle();
        end
        reset_n = 1'b1;
        set_idle();
        do_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
